wb_rr_arbiter: RTL
==================

Name: wb_rr_arbiter

Overview:
Round-robin Wishbone B3 classic arbiter that shares one slave port, e.g. sram0, between up to NUM_MASTERS bus masters such as the picorv32 core and a DMA engine. Once granted, a master holds the bus for as long as its cyc stays high. A per-grant watchdog ends stalled cycles with an error to the master. Sits between the masters and the slave-side intercon port.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..4)
AW, 32, address width
DW, 32, data width (byte-select width = DW/8)
TIMEOUT, 255, stall cycles before abort; 0 disables the watchdog

Ports:
wb_clk_i  in  1  bus clock
wb_rst_i  in  1  asynchronous active-high reset
m_adr_i  in  NUM_MASTERS*AW  master addresses, master k at slice k
m_dat_i  in  NUM_MASTERS*DW  master write data
m_sel_i  in  NUM_MASTERS*DW/8  byte selects
m_we_i  in  NUM_MASTERS  write enables
m_cyc_i  in  NUM_MASTERS  cycle requests
m_stb_i  in  NUM_MASTERS  strobes
m_cti_i  in  NUM_MASTERS*3  cycle type
m_bte_i  in  NUM_MASTERS*2  burst type
m_dat_o  out  DW  slave read data, broadcast to all masters
m_ack_o  out  NUM_MASTERS  per-master ack
m_err_o  out  NUM_MASTERS  per-master error
s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o  out  AW, DW, DW/8, 1, 1, 1, 3, 2  to slave
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave error
grant_o  out  NUM_MASTERS  one-hot current owner (0 = none)
timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, wb_rst_i=1): state IDLE, grant=0, last_owner=NUM_MASTERS-1 so master 0 wins first. All s_* outputs, m_ack_o, m_err_o, grant_o and timeout_o are 0. m_dat_o follows s_dat_i.
- States: IDLE, OWNED, ABORT, all registered.
- IDLE: if any m_cyc_i is high, pick the first requester searching from last_owner+1 with wrap-around. Register grant and last_owner, then go to OWNED. Arbitration latency is 1 cycle. No requests: stay in IDLE.
- OWNED: slave outputs combinationally mux the granted master's slices. s_ack_i and s_err_i route only to the granted bit of m_ack_o/m_err_o; other bits stay 0. When the granted m_cyc_i goes low, go to IDLE and clear grant; s_cyc_o drops the same cycle because the mux is combinational. There is 1 idle cycle between owners.
- Lock: other masters' requests are ignored while the owner keeps cyc high, including across multiple stb/ack transfers.
- Watchdog: counter width is clog2(TIMEOUT+1). It increments each OWNED cycle with s_stb_o=1 and no s_ack_i/s_err_i. It clears on ack, err, stb low, or a grant change. When the counter reaches TIMEOUT-1 and the current cycle has no ack/err:
  - m_err_o[owner]=1 and timeout_o=1 for that cycle;
  - go to ABORT.
- ABORT: s_cyc_o=s_stb_o=0 and all m_ack_o/m_err_o=0. A late s_ack_i is dropped. Return to IDLE when the owner's m_cyc_i goes low.
- Simultaneous s_ack_i and s_err_i: both are forwarded unchanged. Watchdog expiring in the same cycle as ack: ack wins and there is no abort.
- Owner drops cyc while the slave is mid-response: go to IDLE. A following s_ack_i is not forwarded because grant=0.
- TIMEOUT=0: ABORT is unreachable and timeout_o stays 0.

Decomposition:
- Shared package/header: state encoding (IDLE/OWNED/ABORT) and CTI/BTE constants, taken from the existing common Wishbone parameter include.
- Sub-module wb_rr_pick: combinational round-robin picker. Inputs: request vector and last_owner. Outputs: one-hot grant and index. Unit-testable on its own.

Test Plan:
- Single read: m_cyc_i=01, m_stb_i=01, adr0=0x100 at cycle 0 -> cycle 1 grant_o=01, s_cyc_o=1, s_adr_o=0x100. Slave acks at cycle 3 with 0xDEADBEEF -> m_ack_o=01 and m_dat_o=0xDEADBEEF at cycle 3.
- Fairness: both masters request continuously after reset, each drops cyc after one ack -> grants go 01, idle, 10, idle, 01.
- Lock: m0 holds cyc over 3 acked transfers while m1 requests -> grant_o stays 01 throughout; m1 granted 2 cycles after m0 drops cyc; m_ack_o[1] never high during m0 ownership.
- Watchdog: TIMEOUT=16, slave never acks -> on the 16th stalled cycle m_err_o=01 and timeout_o=1 for 1 cycle. s_cyc_o=0 from the next cycle until m0 drops cyc. A late s_ack_i during ABORT is not forwarded.
- Async reset mid-transfer: assert wb_rst_i between clock edges while OWNED -> grant_o=0 and s_cyc_o=0 immediately. After release, m1-only request -> grant_o=10 one cycle later.
- Abandon: m0 drops cyc before ack, slave acks the next cycle -> m_ack_o=00, state returns to IDLE, no timeout_o.

Source files
------------

// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types for the round-robin Wishbone arbiter:
// FSM encoding, CTI/BTE codes and an index-width helper.
package wb_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWNED = 2'd1,
      ST_ABORT = 2'd2
   } arb_state_e;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wb_rr_arbiter_pick.sv
// Combinational round-robin picker: first requester
// after last_i, wrapping, as one-hot grant plus index.
module wb_rr_pick
   import wb_rr_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int IW          = idx_w(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [IW-1:0]          last_i,
   output logic [NUM_MASTERS-1:0] gnt_o,
   output logic [IW-1:0]          idx_o,
   output logic                   valid_o
);

   logic          found;
   logic [IW:0]   sum;
   logic [IW-1:0] j;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      sum   = '0;
      j     = '0;
      // i = NUM_MASTERS lands on last_i itself, so it is tried last
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         sum = {1'b0, last_i} + (IW+1)'(i);
         if (sum >= (IW+1)'(NUM_MASTERS))
            sum = sum - (IW+1)'(NUM_MASTERS);
         j = sum[IW-1:0];
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = j;
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 classic arbiter with bus lock
// while cyc is held and a per-grant stall watchdog.
module wb_rr_arbiter
   import wb_rr_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int TIMEOUT     = 255
) (
   input  logic                        wb_clk_i,
   input  logic                        wb_rst_i,
   input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
   input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
   input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
   input  logic [NUM_MASTERS-1:0]      m_we_i,
   input  logic [NUM_MASTERS-1:0]      m_cyc_i,
   input  logic [NUM_MASTERS-1:0]      m_stb_i,
   input  logic [NUM_MASTERS*3-1:0]    m_cti_i,
   input  logic [NUM_MASTERS*2-1:0]    m_bte_i,
   output logic [DW-1:0]               m_dat_o,
   output logic [NUM_MASTERS-1:0]      m_ack_o,
   output logic [NUM_MASTERS-1:0]      m_err_o,
   output logic [AW-1:0]               s_adr_o,
   output logic [DW-1:0]               s_dat_o,
   output logic [DW/8-1:0]             s_sel_o,
   output logic                        s_we_o,
   output logic                        s_cyc_o,
   output logic                        s_stb_o,
   output logic [2:0]                  s_cti_o,
   output logic [1:0]                  s_bte_o,
   input  logic [DW-1:0]               s_dat_i,
   input  logic                        s_ack_i,
   input  logic                        s_err_i,
   output logic [NUM_MASTERS-1:0]      grant_o,
   output logic                        timeout_o
);

   localparam int   N     = NUM_MASTERS;
   localparam int   SW    = DW / 8;
   localparam int   IW    = idx_w(N);
   localparam int   CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int   TLIM  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic WD_EN = (TIMEOUT > 0);

   arb_state_e    state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [IW-1:0] last_q, last_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [N-1:0]  pick_gnt;
   logic [IW-1:0] pick_idx;
   logic          pick_vld;
   logic          owned;
   logic          own_cyc;
   logic          stall;
   logic          wd_fire;

   wb_rr_pick #(
      .NUM_MASTERS (N),
      .IW          (IW)
   ) u_pick (
      .req_i   (m_cyc_i),
      .last_i  (last_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_vld)
   );

   assign owned   = (state_q == ST_OWNED);
   assign own_cyc = m_cyc_i[last_q];

   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      s_we_o  = 1'b0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_cti_o = CTI_CLASSIC;
      s_bte_o = BTE_LINEAR;
      if (owned) begin
         s_adr_o = m_adr_i[int'(last_q)*AW +: AW];
         s_dat_o = m_dat_i[int'(last_q)*DW +: DW];
         s_sel_o = m_sel_i[int'(last_q)*SW +: SW];
         s_cti_o = m_cti_i[int'(last_q)*3 +: 3];
         s_bte_o = m_bte_i[int'(last_q)*2 +: 2];
         s_we_o  = m_we_i[last_q];
         s_cyc_o = m_cyc_i[last_q];
         s_stb_o = m_stb_i[last_q];
      end
   end

   // ack on the expiry cycle suppresses the abort
   assign stall   = s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;
   assign wd_fire = WD_EN & stall & (cnt_q == CW'(TLIM));

   assign m_dat_o   = s_dat_i;
   assign m_ack_o   = owned ? (grant_q & {N{s_ack_i}}) : '0;
   assign m_err_o   = owned ? (grant_q & {N{s_err_i | wd_fire}}) : '0;
   assign grant_o   = grant_q;
   assign timeout_o = wd_fire;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_d = ST_OWNED;
               grant_d = pick_gnt;
               last_d  = pick_idx;
            end
         end
         ST_OWNED: begin
            if (!own_cyc) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end else if (wd_fire) begin
               state_d = ST_ABORT;
            end else if (stall && WD_EN) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_ABORT: begin
            if (!own_cyc) begin
               state_d = ST_IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= IW'(N - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
